// File: rtl/regfile_pkg.sv
// Shared constants and packed-port slicing helpers for the regfile_sb register file.
package regfile_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int MAX_NUM_RD     = 4;
    localparam int NREG           = 2 ** DEF_ADDR_WIDTH;

    // Number of entries held by a file with the given index width.
    function automatic int num_regs(input int addr_width);
        return 1 << addr_width;
    endfunction

    // LSB of field idx in a packed vector of fields that are width bits wide.
    function automatic int port_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_sb_rd_port.sv
// One read port: the x0 guard, the same-cycle writeback bypass, the array mux and the busy lookup.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]                raddr,
    input  logic                                 wen,
    input  logic [ADDR_WIDTH-1:0]                waddr,
    input  logic [DATA_WIDTH-1:0]                wdata,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  rf,
    input  logic [NUM_REGS-1:0]                  busy,
    output logic [DATA_WIDTH-1:0]                rdata,
    output logic                                 rbusy
);

    // A writeback to the register being read wins over the array and also retires its busy bit.
    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (raddr == '0) begin
            rdata = '0;
            rbusy = 1'b0;
        end else if (wen && (waddr == raddr)) begin
            rdata = wdata;
            rbusy = 1'b0;
        end else begin
            rdata = rf[raddr];
            rbusy = busy[raddr];
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NUM_RD bypassed read ports, one write port and a pending-writeback scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wen,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         issue_valid,
    input  logic [ADDR_WIDTH-1:0]        issue_rd,
    input  logic                         flush,
    output logic [ADDR_WIDTH:0]          pending_cnt
);

    localparam int NUM_REGS = num_regs(ADDR_WIDTH);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rf_q, rf_d;
    logic [NUM_REGS-1:0]                 busy_q, busy_d;
    logic [ADDR_WIDTH:0]                 pending_cnt_q, pending_cnt_d;

    logic wr_hit;
    logic iss_hit;
    logic cnt_inc;
    logic cnt_dec;

    // Writes and issues to x0 are dropped up front so x0 never holds data or a busy bit.
    always_comb begin
        wr_hit  = wen && (waddr != '0);
        iss_hit = issue_valid && (issue_rd != '0);
        // A set only counts on a clear bit; a clear only counts on a set bit that is not re-set this cycle.
        cnt_inc = iss_hit && !busy_q[issue_rd];
        cnt_dec = wr_hit && busy_q[waddr] && !(iss_hit && (issue_rd == waddr));
    end

    // Next-state for the array, scoreboard and pending counter.
    always_comb begin
        rf_d          = rf_q;
        busy_d        = busy_q;
        pending_cnt_d = pending_cnt_q;
        if (rst) begin
            rf_d          = '0;
            busy_d        = '0;
            pending_cnt_d = '0;
        end else begin
            if (wr_hit) begin
                rf_d[waddr] = wdata;
            end
            if (flush) begin
                busy_d        = '0;
                pending_cnt_d = iss_hit ? (ADDR_WIDTH+1)'(1) : '0;
            end else begin
                if (wr_hit) begin
                    busy_d[waddr] = 1'b0;
                end
                pending_cnt_d = pending_cnt_q + (ADDR_WIDTH+1)'(cnt_inc)
                                              - (ADDR_WIDTH+1)'(cnt_dec);
            end
            // Issue is applied last: the younger instruction owns the register.
            if (iss_hit) begin
                busy_d[issue_rd] = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        rf_q          <= rf_d;
        busy_q        <= busy_d;
        pending_cnt_q <= pending_cnt_d;
    end

    assign pending_cnt = pending_cnt_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        rf_read_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_REGS   (NUM_REGS)
        ) u_rd (
            .raddr (raddr[port_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH]),
            .wen   (wen),
            .waddr (waddr),
            .wdata (wdata),
            .rf    (rf_q),
            .busy  (busy_q),
            .rdata (rdata[port_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
            .rbusy (rbusy[i])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a register-level reference model checked every cycle plus literal spot checks.
module tb_regfile_sb;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int NREGS = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              wen;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;
    logic              issue_valid;
    logic [AW-1:0]     issue_rd;
    logic              flush;
    logic [AW:0]       pending_cnt;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    logic [DW-1:0] m_rf   [NREGS];
    bit            m_busy [NREGS];

    regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) dut (
        .clk         (clk),
        .rst         (rst),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .raddr       (raddr),
        .rdata       (rdata),
        .rbusy       (rbusy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int r = 0; r < NREGS; r++) if (m_busy[r]) n++;
        return n;
    endfunction

    // Reference model: architectural register values and outstanding-writeback flags.
    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                m_rf[r]   = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            if (wen && waddr != 0) m_rf[waddr] = wdata;
            if (flush) begin
                for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
            end else if (wen && waddr != 0) begin
                m_busy[waddr] = 1'b0;
            end
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
    end

    // Every-cycle compare of all ports and the counter against the model.
    always @(negedge clk) begin
        if (checking) begin
            for (int p = 0; p < NR; p++) begin
                logic [AW-1:0] a;
                logic [DW-1:0] ed;
                logic          eb;
                a = raddr[p*AW +: AW];
                if (a == 0) begin
                    ed = '0; eb = 1'b0;
                end else if (wen && waddr == a) begin
                    ed = wdata; eb = 1'b0;
                end else begin
                    ed = m_rf[a]; eb = m_busy[a];
                end
                check($sformatf("model rdata%0d", p), 64'(rdata[p*DW +: DW]), 64'(ed));
                check($sformatf("model rbusy%0d", p), 64'(rbusy[p]), 64'(eb));
            end
            check("model pending_cnt", 64'(pending_cnt), 64'(model_count()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = 0; issue_valid = 0; flush = 0; rst = 0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        raddr[p*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return rdata[p*DW +: DW];
    endfunction

    initial begin
        rst = 1; wen = 0; waddr = 0; wdata = 0; raddr = '0;
        issue_valid = 0; issue_rd = 0; flush = 0;
        cyc();
        cyc();
        checking = 1'b1;
        rst = 0;
        #2;
        check("reset pending_cnt", 64'(pending_cnt), 64'd0);

        // Sweep every register on all ports after reset.
        for (int a = 1; a < NREGS; a++) begin
            for (int p = 0; p < NR; p++) set_rd(p, AW'((a + p) % NREGS));
            cyc();
        end
        set_rd(0, 5'd31); #2;
        check("reset r31 rdata0", 64'(rd(0)), 64'd0);

        // Write r5 with bypass, then from the array.
        wen = 1; waddr = 5; wdata = 32'hDEADBEEF; set_rd(0, 5'd5); #2;
        check("bypass r5 rdata0", 64'(rd(0)), 64'hDEADBEEF);
        cyc(); wen = 0; #2;
        check("array r5 rdata0", 64'(rd(0)), 64'hDEADBEEF);
        wen = 1; waddr = 0; wdata = 32'h1234; set_rd(0, 5'd0); #2;
        check("x0 bypass blocked", 64'(rd(0)), 64'd0);
        cyc(); wen = 0; #2;
        check("x0 after write", 64'(rd(0)), 64'd0);

        // Issue r7, then retire it.
        issue_valid = 1; issue_rd = 7; cyc(); issue_valid = 0; set_rd(1, 5'd7); #2;
        check("r7 busy", 64'(rbusy[1]), 64'd1);
        check("r7 pending", 64'(pending_cnt), 64'd1);
        wen = 1; waddr = 7; wdata = 32'h55; #2;
        check("r7 wb rbusy", 64'(rbusy[1]), 64'd0);
        check("r7 wb rdata", 64'(rd(1)), 64'h55);
        cyc(); wen = 0; #2;
        check("r7 retired pending", 64'(pending_cnt), 64'd0);

        // Issue and writeback to r3 together: set wins.
        set_rd(2, 5'd3);
        issue_valid = 1; issue_rd = 3; wen = 1; waddr = 3; wdata = 32'hA3;
        cyc(); idle(); #2;
        check("r3 set-wins busy", 64'(rbusy[2]), 64'd1);
        check("r3 set-wins pending", 64'(pending_cnt), 64'd1);
        issue_valid = 1; issue_rd = 3; wen = 1; waddr = 3; wdata = 32'hB3;
        cyc(); idle(); #2;
        check("r3 again pending", 64'(pending_cnt), 64'd1);
        check("r3 data", 64'(rd(2)), 64'hB3);

        // Clear of an unset bit does not count; issue x0 never sets.
        wen = 1; waddr = 20; wdata = 32'h20; issue_valid = 1; issue_rd = 0;
        cyc(); idle(); #2;
        check("clear unset pending", 64'(pending_cnt), 64'd1);

        // Build r1,r2,r3 busy, re-issue r1, then retire r3 while issuing r4.
        issue_valid = 1; issue_rd = 1; cyc();
        issue_rd = 2; cyc();
        issue_rd = 1; cyc(); idle(); #2;
        check("re-set no count", 64'(pending_cnt), 64'd3);
        issue_valid = 1; issue_rd = 4; wen = 1; waddr = 3; wdata = 32'hC3;
        cyc(); idle(); #2;
        check("swap pending", 64'(pending_cnt), 64'd3);
        issue_valid = 1; issue_rd = 3; cyc(); idle(); #2;
        check("four pending", 64'(pending_cnt), 64'd4);

        // Flush with simultaneous issue of r9.
        set_rd(0, 5'd1); set_rd(1, 5'd2); set_rd(2, 5'd3); set_rd(3, 5'd9);
        flush = 1; issue_valid = 1; issue_rd = 9; cyc(); idle(); #2;
        check("flush pending", 64'(pending_cnt), 64'd1);
        check("flush rbusy", 64'(rbusy), 64'b1000);
        flush = 1; wen = 1; waddr = 9; wdata = 32'h99; cyc(); idle(); #2;
        check("flush only pending", 64'(pending_cnt), 64'd0);

        // Fill r10..r13, make r11 busy, then reset with a write in flight.
        for (int k = 0; k < 4; k++) begin
            wen = 1; waddr = AW'(10 + k); wdata = 32'h1000_0000 + 32'(k * 17 + 3);
            cyc();
        end
        wen = 0; issue_valid = 1; issue_rd = 11; cyc(); idle();
        for (int p = 0; p < NR; p++) set_rd(p, AW'(10 + p));
        #2;
        check("r12 before reset", 64'(rd(2)), 64'h1000_0025);
        check("r11 busy before reset", 64'(rbusy), 64'b0010);
        rst = 1; wen = 1; waddr = 12; wdata = 32'hFACE; issue_valid = 1; issue_rd = 14; flush = 1;
        #2;
        check("bypass during reset", 64'(rd(2)), 64'hFACE);
        cyc(); idle(); #2;
        check("post-reset rdata", 64'(rdata), 64'd0);
        check("post-reset rbusy", 64'(rbusy), 64'd0);
        check("post-reset pending", 64'(pending_cnt), 64'd0);
        cyc();

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
